psum_acc_ctrl: RTL and testbench

- Sequences the synchronous dual-port psum memory (1-cycle read latency; write has priority over read).
- Accepts pairs of partial sums from the PE array and either overwrites (first pass) or read-modify-write accumulates them into the memory.
- On request, drains accumulated psums to the output stage.
- Sits between the PE array psum outputs and the psum memory. It is the only master of the memory ports.

---
 rtl/psum_acc_ctrl_pkg.sv | 21 ++
 rtl/psum_sat_add.sv | 34 +++
 rtl/psum_acc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_psum_acc_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_ctrl_pkg.sv
// Purpose : shared types and constants for the psum accumulation controller.
// Contents: controller state encoding, default psum width, saturation bounds.
// Users   : psum_acc_ctrl, psum_sat_add.
package psum_acc_ctrl_pkg;

    // Default psum width; the saturation bounds follow from it.
    localparam int PSUM_DW = 8;
    localparam int SAT_MAX = (1 << (PSUM_DW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (PSUM_DW - 1));

    typedef enum logic [2:0] {
        IDLE,
        OVR,
        ACC_RD,
        ACC_WR,
        DRN,
        DTAIL,
        FIN
    } state_t;

endpackage

// File: rtl/psum_sat_add.sv
// Purpose : two independent signed saturating adders (one per psum lane).
// Latency : combinational, zero cycles.
// Ports   : i_a0/i_b0 -> o_sum0, i_a1/i_b1 -> o_sum1, all DATA_WIDTH signed.
module psum_sat_add
    import psum_acc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DW
) (
    input  logic [DATA_WIDTH-1:0] i_a0,
    input  logic [DATA_WIDTH-1:0] i_b0,
    input  logic [DATA_WIDTH-1:0] i_a1,
    input  logic [DATA_WIDTH-1:0] i_b1,
    output logic [DATA_WIDTH-1:0] o_sum0,
    output logic [DATA_WIDTH-1:0] o_sum1
);

    // Add with one guard bit; overflow shows up as the guard bit disagreeing
    // with the result sign, and the guard bit then tells which rail to clamp to.
    function automatic logic [DATA_WIDTH-1:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            return {s[DATA_WIDTH], {(DATA_WIDTH-1){~s[DATA_WIDTH]}}};
        end
        return s[DATA_WIDTH-1:0];
    endfunction

    assign o_sum0 = sat_add(i_a0, i_b0);
    assign o_sum1 = sat_add(i_a1, i_b1);

endmodule

// File: rtl/psum_acc_ctrl.sv
// Purpose : sequences the dual-port psum memory: overwrite pass, read-modify-write
//           accumulate pass (saturating), and drain of stored pairs to the output stage.
// Ports   : i_start/i_drain/i_len/i_first_pass command; i_psum_* / o_psum_ready input
//           pairs; o_mem_* / i_mem_rd_data* memory master; o_out_* drain; o_busy/o_done.
module psum_acc_ctrl
    import psum_acc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DW,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_first_pass,
    input  logic                  i_drain,
    input  logic [ADDR_WIDTH-1:0] i_len,
    input  logic                  i_psum_valid,
    output logic                  o_psum_ready,
    input  logic [DATA_WIDTH-1:0] i_psum0,
    input  logic [DATA_WIDTH-1:0] i_psum1,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr0,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr1,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data0,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data1,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr0,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr1,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data0,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data1,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data0,
    output logic [DATA_WIDTH-1:0] o_out_data1,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH-1:0] HALF_DEPTH = ADDR_WIDTH'(DEPTH / 2);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0] lat0_q, lat0_d;
    logic [DATA_WIDTH-1:0] lat1_q, lat1_d;
    logic                  out_vld_q, out_vld_d;

    logic [ADDR_WIDTH-1:0] len_eff;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  last_pair;
    logic [DATA_WIDTH-1:0] sum0;
    logic [DATA_WIDTH-1:0] sum1;

    // Requests longer than the memory holds are clamped to the used depth.
    assign len_eff   = (i_len > HALF_DEPTH) ? HALF_DEPTH : i_len;
    assign addr0     = {k_q[ADDR_WIDTH-2:0], 1'b0};
    assign addr1     = {k_q[ADDR_WIDTH-2:0], 1'b1};
    assign last_pair = ((k_q + ONE) == len_q);

    // Read data arriving in ACC_WR is the stored psum for the pair latched in ACC_RD.
    psum_sat_add #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat_add (
        .i_a0   (i_mem_rd_data0),
        .i_b0   (lat0_q),
        .i_a1   (i_mem_rd_data1),
        .i_b1   (lat1_q),
        .o_sum0 (sum0),
        .o_sum1 (sum1)
    );

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        len_d          = len_q;
        lat0_d         = lat0_q;
        lat1_d         = lat1_q;
        out_vld_d      = 1'b0;
        o_psum_ready   = 1'b0;
        o_mem_wr_en    = 1'b0;
        o_mem_wr_addr0 = '0;
        o_mem_wr_addr1 = '0;
        o_mem_wr_data0 = '0;
        o_mem_wr_data1 = '0;
        o_mem_rd_en    = 1'b0;
        o_mem_rd_addr0 = '0;
        o_mem_rd_addr1 = '0;
        o_done         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start || i_drain) begin
                    k_d   = '0;
                    len_d = len_eff;
                    if (len_eff == '0) begin
                        state_d = FIN;
                    end else if (i_start) begin
                        state_d = i_first_pass ? OVR : ACC_RD;
                    end else begin
                        state_d = DRN;
                    end
                end
            end
            OVR: begin
                o_psum_ready = 1'b1;
                if (i_psum_valid) begin
                    o_mem_wr_en    = 1'b1;
                    o_mem_wr_addr0 = addr0;
                    o_mem_wr_addr1 = addr1;
                    o_mem_wr_data0 = i_psum0;
                    o_mem_wr_data1 = i_psum1;
                    k_d            = k_q + ONE;
                    if (last_pair) begin
                        state_d = FIN;
                    end
                end
            end
            ACC_RD: begin
                o_psum_ready = 1'b1;
                if (i_psum_valid) begin
                    lat0_d         = i_psum0;
                    lat1_d         = i_psum1;
                    o_mem_rd_en    = 1'b1;
                    o_mem_rd_addr0 = addr0;
                    o_mem_rd_addr1 = addr1;
                    state_d        = ACC_WR;
                end
            end
            ACC_WR: begin
                o_mem_wr_en    = 1'b1;
                o_mem_wr_addr0 = addr0;
                o_mem_wr_addr1 = addr1;
                o_mem_wr_data0 = sum0;
                o_mem_wr_data1 = sum1;
                k_d            = k_q + ONE;
                state_d        = last_pair ? FIN : ACC_RD;
            end
            DRN: begin
                o_mem_rd_en    = 1'b1;
                o_mem_rd_addr0 = addr0;
                o_mem_rd_addr1 = addr1;
                out_vld_d      = 1'b1;
                k_d            = k_q + ONE;
                if (last_pair) begin
                    state_d = DTAIL;
                end
            end
            DTAIL: begin
                // The final read's data is on the bus this cycle via out_vld_q.
                state_d = FIN;
            end
            FIN: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            len_q     <= '0;
            lat0_q    <= '0;
            lat1_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            len_q     <= len_d;
            lat0_q    <= lat0_d;
            lat1_q    <= lat1_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Drain data is the memory read data passed straight through, gated to zero
    // whenever no drained beat is on the bus.
    assign o_out_valid = out_vld_q;
    assign o_out_data0 = out_vld_q ? i_mem_rd_data0 : '0;
    assign o_out_data1 = out_vld_q ? i_mem_rd_data1 : '0;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_psum_acc_ctrl.sv
module tb_psum_acc_ctrl;
    import psum_acc_ctrl_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int HALF  = DEPTH / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          first_pass = 1'b0;
    logic          drain = 1'b0;
    logic [AW-1:0] len = '0;
    logic          psum_valid = 1'b0;
    logic [DW-1:0] psum0 = '0;
    logic [DW-1:0] psum1 = '0;
    logic          psum_ready;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] wr_a0, wr_a1, rd_a0, rd_a1;
    logic [DW-1:0] wr_d0, wr_d1;
    logic [DW-1:0] rd_d0, rd_d1;
    logic          out_valid;
    logic [DW-1:0] out_d0, out_d1;
    logic          busy, done;

    always #5 clk = ~clk;

    psum_acc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_first_pass   (first_pass),
        .i_drain        (drain),
        .i_len          (len),
        .i_psum_valid   (psum_valid),
        .o_psum_ready   (psum_ready),
        .i_psum0        (psum0),
        .i_psum1        (psum1),
        .o_mem_wr_en    (mem_wr_en),
        .o_mem_wr_addr0 (wr_a0),
        .o_mem_wr_addr1 (wr_a1),
        .o_mem_wr_data0 (wr_d0),
        .o_mem_wr_data1 (wr_d1),
        .o_mem_rd_en    (mem_rd_en),
        .o_mem_rd_addr0 (rd_a0),
        .o_mem_rd_addr1 (rd_a1),
        .i_mem_rd_data0 (rd_d0),
        .i_mem_rd_data1 (rd_d1),
        .o_out_valid    (out_valid),
        .o_out_data0    (out_d0),
        .o_out_data1    (out_d1),
        .o_busy         (busy),
        .o_done         (done)
    );

    // Synchronous dual-port memory, one-cycle read latency, untouched by reset.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[wr_a0] <= wr_d0;
            mem[wr_a1] <= wr_d1;
        end
        if (mem_rd_en) begin
            rd_d0 <= mem[rd_a0];
            rd_d1 <= mem[rd_a1];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference model: psum contents as plain integers plus expected traffic.
    int            ref_mem [0:DEPTH-1];
    logic [31:0]   exp_wr[$];
    logic [15:0]   exp_out[$];
    int            pa0 [0:HALF-1];
    int            pa1 [0:HALF-1];

    function automatic int sat(input int a, input int b);
        int s;
        s = a + b;
        if (s > SAT_MAX) return SAT_MAX;
        if (s < SAT_MIN) return SAT_MIN;
        return s;
    endfunction

    function automatic int rnd_psum();
        logic [7:0] b;
        b = 8'($urandom);
        return int'($signed(b));
    endfunction

    int cyc = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int out_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [31:0] ew;
        logic [15:0] eo;
        if (rst_n) begin
            check("rd_wr_excl", 80'(mem_rd_en & mem_wr_en), 80'(0));
            if (mem_rd_en) rd_seen <= rd_seen + 1;
            if (mem_wr_en) begin
                wr_seen <= wr_seen + 1;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 80'(1), 80'(0));
                end else begin
                    ew = exp_wr.pop_front();
                    check("wr_beat", {48'(0), wr_a0, wr_a1, wr_d0, wr_d1}, {48'(0), ew});
                end
            end
            if (out_valid) begin
                out_seen <= out_seen + 1;
                if (exp_out.size() == 0) begin
                    check("out_unexpected", 80'(1), 80'(0));
                end else begin
                    eo = exp_out.pop_front();
                    check("out_beat", {64'(0), out_d0, out_d1}, {64'(0), eo});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int t0, input int exp_lat, input string tag);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
            if (n > 300) begin
                check({tag, "_timeout"}, 80'(1), 80'(0));
                step();
                return;
            end
            @(posedge clk);
            #1;
        end
        if (exp_lat >= 0) check({tag, "_lat"}, 80'(cyc - t0 + 1), 80'(exp_lat));
        step();
        @(negedge clk);
        check({tag, "_idle"}, {78'(0), busy, done}, 80'(0));
        step();
    endtask

    task automatic drive_pair(input int a, input int b, input int gap, input bit noise);
        logic acc;
        for (int g = 0; g < gap; g++) begin
            psum_valid = 1'b0;
            drain      = noise && ($urandom_range(0, 1) == 1);
            start      = noise && ($urandom_range(0, 1) == 1);
            first_pass = 1'($urandom_range(0, 1));
            step();
        end
        drain      = 1'b0;
        start      = 1'b0;
        psum_valid = 1'b1;
        psum0      = 8'(a);
        psum1      = 8'(b);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = psum_ready;
            step();
            if (acc) begin
                psum_valid = 1'b0;
                return;
            end
        end
        psum_valid = 1'b0;
        check("handshake_timeout", 80'(1), 80'(0));
    endtask

    // One accumulate/overwrite pass using pa0/pa1. bp_gap>0 forces that many idle
    // cycles before pair 1; otherwise gaps are random up to gapmax.
    task automatic run_pass(input bit fp, input int l, input int gapmax, input bit noise,
                            input bit both, input int bp_gap, input int exp_lat, input string tag);
        int le, w0, r0, o0, t0, v0, v1, gap;
        le = (l > HALF) ? HALF : l;
        w0 = wr_seen; r0 = rd_seen; o0 = out_seen;
        for (int k = 0; k < le; k++) begin
            v0 = fp ? pa0[k] : sat(ref_mem[2*k],   pa0[k]);
            v1 = fp ? pa1[k] : sat(ref_mem[2*k+1], pa1[k]);
            ref_mem[2*k]   = v0;
            ref_mem[2*k+1] = v1;
            exp_wr.push_back({8'(2*k), 8'(2*k+1), 8'(v0), 8'(v1)});
        end
        start = 1'b1; first_pass = fp; drain = both; len = AW'(l);
        step();
        start = 1'b0; drain = 1'b0;
        t0 = cyc;
        for (int k = 0; k < le; k++) begin
            gap = (bp_gap > 0) ? ((k == 1) ? bp_gap : 0) : int'($urandom_range(0, gapmax));
            drive_pair(pa0[k], pa1[k], gap, noise);
        end
        wait_done(t0, exp_lat, tag);
        check({tag, "_wrcnt"}, 80'(wr_seen - w0), 80'(le));
        check({tag, "_rdcnt"}, 80'(rd_seen - r0), 80'(fp ? 0 : le));
        check({tag, "_outcnt"}, 80'(out_seen - o0), 80'(0));
        check({tag, "_wrq"}, 80'(exp_wr.size()), 80'(0));
    endtask

    task automatic run_drain(input int l, input string tag);
        int le, w0, r0, o0, t0;
        le = (l > HALF) ? HALF : l;
        w0 = wr_seen; r0 = rd_seen; o0 = out_seen;
        for (int k = 0; k < le; k++) begin
            exp_out.push_back({8'(ref_mem[2*k]), 8'(ref_mem[2*k+1])});
        end
        drain = 1'b1; len = AW'(l);
        step();
        drain = 1'b0;
        t0 = cyc;
        wait_done(t0, (le == 0) ? 1 : le + 2, tag);
        check({tag, "_outcnt"}, 80'(out_seen - o0), 80'(le));
        check({tag, "_rdcnt"}, 80'(rd_seen - r0), 80'(le));
        check({tag, "_wrcnt"}, 80'(wr_seen - w0), 80'(0));
        check({tag, "_outq"}, 80'(exp_out.size()), 80'(0));
    endtask

    initial begin
        int op, l;
        #2 rst_n = 1'b0;
        #1;
        check("reset_mem_if", {29'(0), psum_ready, mem_wr_en, wr_a0, wr_a1, wr_d0, wr_d1,
                               mem_rd_en, rd_a0, rd_a1}, 80'(0));
        check("reset_out_if", {61'(0), out_valid, out_d0, out_d1, busy, done}, 80'(0));
        step(); step();
        rst_n = 1'b1;
        step();

        // Fill every used entry so later accumulates start from known data.
        for (int k = 0; k < HALF; k++) begin pa0[k] = rnd_psum(); pa1[k] = rnd_psum(); end
        run_pass(1'b1, HALF, 0, 1'b0, 1'b0, 0, HALF + 1, "init_fill");

        pa0[0] = 5; pa1[0] = 6; pa0[1] = 7; pa1[1] = 8;
        run_pass(1'b1, 2, 0, 1'b0, 1'b0, 0, 3, "first_pass");
        run_drain(2, "drain_fp");

        pa0[0] = 1; pa1[0] = -2; pa0[1] = 3; pa1[1] = 4;
        run_pass(1'b0, 2, 0, 1'b0, 1'b0, 0, 5, "accum");
        run_drain(2, "drain_acc");

        pa0[0] = 120; pa1[0] = -120;
        run_pass(1'b1, 1, 0, 1'b0, 1'b0, 0, 2, "sat_load");
        pa0[0] = 20; pa1[0] = -20;
        run_pass(1'b0, 1, 0, 1'b0, 1'b0, 0, 3, "sat_acc");
        run_drain(1, "drain_sat");

        for (int k = 0; k < HALF; k++) begin pa0[k] = rnd_psum(); pa1[k] = rnd_psum(); end
        run_pass(1'b0, 3, 0, 1'b0, 1'b0, 3, 9, "backpressure");
        run_drain(3, "drain_bp");

        run_pass(1'b1, 0, 0, 1'b0, 1'b0, 0, 1, "len0_fp");
        run_pass(1'b0, 0, 0, 1'b0, 1'b0, 0, 1, "len0_acc");
        run_drain(0, "len0_drain");

        for (int k = 0; k < HALF; k++) begin pa0[k] = rnd_psum(); pa1[k] = rnd_psum(); end
        run_pass(1'b1, 200, 0, 1'b0, 1'b0, 0, HALF + 1, "len200");
        run_drain(200, "drain_len200");

        pa0[0] = -3; pa1[0] = 9; pa0[1] = 44; pa1[1] = -7;
        run_pass(1'b1, 2, 0, 1'b0, 1'b1, 0, 3, "start_and_drain");

        // Reset while pair 1's accumulate write is on the bus.
        pa0[0] = 10; pa1[0] = 20;
        ref_mem[0] = sat(ref_mem[0], 10);
        ref_mem[1] = sat(ref_mem[1], 20);
        exp_wr.push_back({8'(0), 8'(1), 8'(ref_mem[0]), 8'(ref_mem[1])});
        start = 1'b1; first_pass = 1'b0; len = AW'(2);
        step();
        start = 1'b0;
        drive_pair(10, 20, 0, 1'b0);
        drive_pair(30, 40, 0, 1'b0);
        check("rst_pre_wr", 80'(mem_wr_en), 80'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_if", {29'(0), psum_ready, mem_wr_en, wr_a0, wr_a1, wr_d0, wr_d1,
                                 mem_rd_en, rd_a0, rd_a1}, 80'(0));
        check("rst_mid_out_if", {61'(0), out_valid, out_d0, out_d1, busy, done}, 80'(0));
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_idle", 80'(busy), 80'(0));
        check("rst_wrq", 80'(exp_wr.size()), 80'(0));
        exp_wr.delete();
        run_drain(2, "drain_after_rst");

        for (int it = 0; it < 24; it++) begin
            op = int'($urandom_range(0, 2));
            l  = int'($urandom_range(0, 12));
            for (int k = 0; k < HALF; k++) begin pa0[k] = rnd_psum(); pa1[k] = rnd_psum(); end
            if (op == 2) run_drain(l, "rnd_drain");
            else run_pass(op == 0, l, int'($urandom_range(0, 3)), 1'b1, 1'b0, 0, -1, "rnd_pass");
        end
        run_drain(HALF, "final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
